// File: rtl/decode_stage.sv
// Decode slot between fetch and execute: holds one instruction, extracts fields, resolves branches/jumps.
// Latency: an instruction accepted at edge N is presented on out_* from cycle N+1; one instruction per cycle.
// Backpressure: in_ready drops while the slot is held and not firing; load-use and branch-operand hazards hold the slot.
// Optional build macro DECODE_JR_EN: treat JR/JALR as register-target jumps resolved here.
module decode_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [31:0]        in_instr,
    output logic [RADDR_W-1:0] rs_addr,
    output logic [RADDR_W-1:0] rt_addr,
    input  logic [XLEN-1:0]    rs_data,
    input  logic [XLEN-1:0]    rt_data,
    input  logic               ex_load_valid,
    input  logic               ex_wr_valid,
    input  logic [RADDR_W-1:0] ex_wr_reg,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_rs_word,
    output logic [XLEN-1:0]    out_rt_word,
    output logic [31:0]        out_instr,
    output logic [5:0]         out_op,
    output logic [5:0]         out_func,
    output logic [RADDR_W-1:0] out_rs,
    output logic [RADDR_W-1:0] out_rt,
    output logic [RADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]    out_link,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_addr,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    // Everything the slot keeps about the held instruction travels together.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } slot_t;

    slot_t held;
    logic  held_valid;

    logic [5:0]      op;
    logic [5:0]      func;
    logic [15:0]     imm16;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jmp_target;

    logic is_beq, is_bne, is_blez, is_bgtz, is_j, is_jal, is_jr;
    logic reads_branch_operands;
    logic uses_rt;
    logic match_rs, match_rt;
    logic hazard;
    logic fire;
    logic taken;
    logic [XLEN-1:0] target;

    // ------------------------------------------------------------------
    // Field extraction from the held instruction (valid or not).
    // ------------------------------------------------------------------
    assign op       = held.instr[31:26];
    assign func     = held.instr[5:0];
    assign imm16    = held.instr[15:0];
    assign imm_sext = {{(XLEN-16){imm16[15]}}, imm16};

    assign rs_addr  = RADDR_W'(held.instr[25:21]);
    assign rt_addr  = RADDR_W'(held.instr[20:16]);

    assign is_beq   = (op == OP_BEQ);
    assign is_bne   = (op == OP_BNE);
    assign is_blez  = (op == OP_BLEZ);
    assign is_bgtz  = (op == OP_BGTZ);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);

`ifdef DECODE_JR_EN
    assign is_jr    = (op == OP_SPECIAL) && ((func == FN_JR) || (func == FN_JALR));
`else
    assign is_jr    = 1'b0;
`endif

    // Instructions whose outcome depends on register values this cycle.
    assign reads_branch_operands = is_beq | is_bne | is_blez | is_bgtz | is_jr;

    // Single-source instructions never wait on their rt field.
    assign uses_rt  = !(is_blez | is_bgtz | is_jr);

    // ------------------------------------------------------------------
    // Interlock: loads cannot forward in time for anything; ALU results
    // cannot forward in time for decode-stage branch comparison.
    // $0 is never a real dependency.
    // ------------------------------------------------------------------
    assign match_rs = (ex_wr_reg == rs_addr);
    assign match_rt = uses_rt && (ex_wr_reg == rt_addr);

    assign hazard   = held_valid
                   && (ex_wr_reg != '0)
                   && (match_rs || match_rt)
                   && (ex_load_valid || (ex_wr_valid && reads_branch_operands));

    assign out_valid = held_valid && !hazard && !flush;
    assign fire      = out_valid && out_ready;
    assign in_ready  = !held_valid || fire;

    // ------------------------------------------------------------------
    // Branch/jump resolution.
    // ------------------------------------------------------------------
    assign br_target  = held.pc + XLEN'(4) + (imm_sext << 2);
    assign jmp_target = {held.pc[XLEN-1:28], held.instr[25:0], 2'b00};

    // Select taken flag and target by opcode; BLEZ/BGTZ compare signed against zero.
    always_comb begin
        taken  = 1'b0;
        target = '0;
        if (is_beq) begin
            taken  = (rs_data == rt_data);
            target = br_target;
        end else if (is_bne) begin
            taken  = (rs_data != rt_data);
            target = br_target;
        end else if (is_blez) begin
            taken  = ($signed(rs_data) <= $signed({XLEN{1'b0}}));
            target = br_target;
        end else if (is_bgtz) begin
            taken  = ($signed(rs_data) > $signed({XLEN{1'b0}}));
            target = br_target;
        end else if (is_j || is_jal) begin
            taken  = 1'b1;
            target = jmp_target;
        end else if (is_jr) begin
            taken  = 1'b1;
            target = rs_data;
        end
    end

    // Redirect only on the handshake cycle so a stalled branch redirects once.
    assign redirect_valid = fire && taken;
    assign redirect_addr  = redirect_valid ? target : '0;

    // ------------------------------------------------------------------
    // Outputs to execute.
    // ------------------------------------------------------------------
    assign out_pc      = held.pc;
    assign out_instr   = held.instr;
    assign out_op      = op;
    assign out_func    = func;
    assign out_rs      = rs_addr;
    assign out_rt      = rt_addr;
    assign out_rd      = RADDR_W'(held.instr[15:11]);
    assign out_rs_word = rs_data;
    assign out_rt_word = rt_data;
    assign out_link    = held.pc + XLEN'(8);

    // Slot register: flush beats a new load, a new load beats draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_valid <= 1'b0;
            held       <= '0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            held_valid <= 1'b1;
            held.pc    <= in_pc;
            held.instr <= in_instr;
        end else if (fire) begin
            held_valid <= 1'b0;
        end
    end

    // Count bubble cycles caused by interlocks; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (hazard && !flush) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
